// File: rtl/divide_extension_if.sv
// -----------------------------------------------------------------------------
// divide_extension_if
// Request/response bundle between the control unit and the RV32M divider.
//   i_start   : request, sampled only while the divider is idle
//   i_flush   : synchronous abort of an in-flight operation
//   i_funct3  : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_op_a    : dividend (rs1), needed only at the start edge
//   i_op_b    : divisor  (rs2), needed only at the start edge
//   o_busy    : high whenever the divider is not idle
//   o_valid   : one-cycle pulse, o_result is valid in that cycle
//   o_result  : quotient or remainder, held until the next o_valid
// master drives requests (control unit), slave is the divider.
// -----------------------------------------------------------------------------
interface divide_extension_if #(
  parameter int XLEN = 32
) ();
  logic            i_start;
  logic            i_flush;
  logic [1:0]      i_funct3;
  logic [XLEN-1:0] i_op_a;
  logic [XLEN-1:0] i_op_b;
  logic            o_busy;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_flush, i_funct3, i_op_a, i_op_b,
    input  o_busy, o_valid, o_result
  );

  modport slave (
    input  i_start, i_flush, i_funct3, i_op_a, i_op_b,
    output o_busy, o_valid, o_result
  );
endinterface

// File: rtl/divide_extension.sv
// -----------------------------------------------------------------------------
// divide_extension
// Sequential RV32M divider (DIV, DIVU, REM, REMU), radix-2 restoring, one
// quotient bit per clock. Divide-by-zero and signed overflow finish in one
// cycle without iterating.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : divide_extension_if.slave (start/flush/op select/operands in,
//              busy/valid/result out)
// -----------------------------------------------------------------------------
module divide_extension #(
  parameter int XLEN = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  divide_extension_if.slave   bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_LAST = {CW{1'b1}};

  logic [1:0]      state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [XLEN-1:0] quo_q,    quo_d;
  logic [XLEN-1:0] rem_q,    rem_d;
  logic [XLEN-1:0] div_q,    div_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q,  valid_d;
  logic            busy_q,   busy_d;

  // Operand decode at capture time.
  logic            is_signed_s, a_neg_s, b_neg_s, div0_s, ovf_s;
  logic [XLEN-1:0] abs_a_s, abs_b_s, special_s;

  // One restoring step; the shifted partial remainder needs XLEN+1 bits.
  logic [XLEN:0]   shift_s, diff_s;
  logic            ge_s;
  logic [XLEN-1:0] quo_nx_s, rem_nx_s, final_s;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    return ~x + ONE;
  endfunction

  // Operand magnitudes, signs and single-cycle special-case results.
  always_comb begin
    is_signed_s = ~bus.i_funct3[0];
    a_neg_s     = is_signed_s & bus.i_op_a[XLEN-1];
    b_neg_s     = is_signed_s & bus.i_op_b[XLEN-1];
    abs_a_s     = a_neg_s ? negate(bus.i_op_a) : bus.i_op_a;
    abs_b_s     = b_neg_s ? negate(bus.i_op_b) : bus.i_op_b;
    div0_s      = (bus.i_op_b == ZERO);
    ovf_s       = is_signed_s & (bus.i_op_a == MIN_NEG) & (bus.i_op_b == ONES);
    if (div0_s) begin
      special_s = bus.i_funct3[1] ? bus.i_op_a : ONES;
    end else if (ovf_s) begin
      special_s = bus.i_funct3[1] ? ZERO : MIN_NEG;
    end else begin
      special_s = ZERO;
    end
  end

  // Restoring iteration and sign fix-up of the final step's result.
  always_comb begin
    shift_s  = {rem_q, quo_q[XLEN-1]};
    ge_s     = (shift_s >= {1'b0, div_q});
    diff_s   = shift_s - {1'b0, div_q};
    rem_nx_s = ge_s ? diff_s[XLEN-1:0] : shift_s[XLEN-1:0];
    quo_nx_s = {quo_q[XLEN-2:0], ge_s};
    if (is_rem_q) begin
      final_s = neg_rem_q ? negate(rem_nx_s) : rem_nx_s;
    end else begin
      final_s = neg_quo_q ? negate(quo_nx_s) : quo_nx_s;
    end
  end

  // Next-state logic; flush wins over both start and completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start && !bus.i_flush) begin
          quo_d     = abs_a_s;
          rem_d     = ZERO;
          div_d     = abs_b_s;
          cnt_d     = CNT_ZERO;
          is_rem_d  = bus.i_funct3[1];
          neg_quo_d = a_neg_s ^ b_neg_s;
          neg_rem_d = a_neg_s;
          if (div0_s || ovf_s) begin
            result_d = special_s;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.i_flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d = quo_nx_s;
          rem_d = rem_nx_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            result_d = final_s;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    valid_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      quo_q     <= ZERO;
      rem_q     <= ZERO;
      div_q     <= ZERO;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= ZERO;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_busy   = busy_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;

endmodule

// File: tb/tb_divide_extension.sv
// -----------------------------------------------------------------------------
// tb_divide_extension
// Directed and randomized checks of the RV32M divider against an arithmetic
// reference model (64-bit signed/unsigned division with RISC-V special cases).
// -----------------------------------------------------------------------------
module tb_divide_extension;

  localparam logic [1:0] F_DIV  = 2'b00;
  localparam logic [1:0] F_DIVU = 2'b01;
  localparam logic [1:0] F_REM  = 2'b10;
  localparam logic [1:0] F_REMU = 2'b11;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  divide_extension_if #(.XLEN(32)) bus ();

  divide_extension #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with wide plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, r;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (f[0]) begin
      sa = longint'(a);
      sb = longint'(b);
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    r = f[1] ? (sa % sb) : (sa / sb);
    return r[31:0];
  endfunction

  function automatic int ref_latency(input logic [1:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic drive_start(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_funct3 = f;
    bus.i_op_a   = a;
    bus.i_op_b   = b;
  endtask

  // Waits at negedges for o_valid; lat counts cycles since the start edge.
  task automatic wait_valid(input int k_now, output int lat, output int bcnt);
    lat  = k_now;
    bcnt = 0;
    while (bus.o_valid !== 1'b1 && lat < 64) begin
      if (bus.o_busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (bus.o_busy === 1'b1) bcnt++;
    if (lat >= 64) chk("valid_timeout", {31'd0, bus.o_valid}, 32'd1);
  endtask

  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bcnt);
    drive_start(f, a, b);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_op_a  = $urandom;
    bus.i_op_b  = $urandom;
    wait_valid(1, lat, bcnt);
    res = bus.o_result;
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [1:0]  f;
    int          lat, bcnt, seen, sel;

    total = 0;
    bad   = 0;
    rst_n        = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_flush  = 1'b0;
    bus.i_funct3 = 2'b00;
    bus.i_op_a   = 32'd0;
    bus.i_op_b   = 32'd0;

    #12;
    chk("reset_busy",   {31'd0, bus.o_busy},  32'd0);
    chk("reset_valid",  {31'd0, bus.o_valid}, 32'd0);
    chk("reset_result", bus.o_result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: signed division and remainders
    do_op(F_DIV, 32'd20, 32'hFFFF_FFFD, res, lat, bcnt);
    chk("div_20_m3", res, 32'hFFFF_FFFA);
    chk("div_20_m3_lat", 32'(lat), 32'd33);
    @(negedge clk);
    chk("valid_pulse", {31'd0, bus.o_valid}, 32'd0);
    chk("idle_after_done", {31'd0, bus.o_busy}, 32'd0);
    do_op(F_REM, 32'd20, 32'hFFFF_FFFD, res, lat, bcnt);
    chk("rem_20_m3", res, 32'd2);
    do_op(F_REM, 32'hFFFF_FFEC, 32'd3, res, lat, bcnt);
    chk("rem_m20_3", res, 32'hFFFF_FFFE);

    // 2: unsigned, busy length
    do_op(F_DIVU, 32'hFFFF_FFFF, 32'd2, res, lat, bcnt);
    chk("divu_max_2", res, 32'h7FFF_FFFF);
    chk("divu_busy_cycles", 32'(bcnt), 32'd33);
    do_op(F_REMU, 32'hFFFF_FFFF, 32'd2, res, lat, bcnt);
    chk("remu_max_2", res, 32'd1);

    // 3: divide by zero
    do_op(F_DIV, 32'd7, 32'd0, res, lat, bcnt);
    chk("div_by_zero", res, 32'hFFFF_FFFF);
    chk("div_by_zero_lat", 32'(lat), 32'd1);
    do_op(F_REMU, 32'd7, 32'd0, res, lat, bcnt);
    chk("remu_by_zero", res, 32'd7);

    // 4: signed overflow
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcnt);
    chk("div_ovf", res, 32'h8000_0000);
    chk("div_ovf_lat", 32'(lat), 32'd1);
    do_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcnt);
    chk("rem_ovf", res, 32'd0);

    // 5a: start pulse during CALC is ignored
    drive_start(F_DIV, 32'd20, 32'hFFFF_FFFD);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_funct3 = F_DIVU;
    bus.i_op_a   = 32'd100;
    bus.i_op_b   = 32'd7;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_valid(6, lat, bcnt);
    chk("ignored_start_result", bus.o_result, 32'hFFFF_FFFA);
    chk("ignored_start_lat", 32'(lat), 32'd33);

    // 5b: flush during CALC
    drive_start(F_DIVU, 32'h0000_FFFF, 32'd3);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("flush_busy", {31'd0, bus.o_busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      if (bus.o_valid === 1'b1) seen++;
      @(negedge clk);
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    chk("flush_result_held", bus.o_result, 32'hFFFF_FFFA);

    // 5c: flush together with start in IDLE drops the start
    bus.i_start  = 1'b1;
    bus.i_flush  = 1'b1;
    bus.i_funct3 = F_DIVU;
    bus.i_op_a   = 32'd9;
    bus.i_op_b   = 32'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    chk("flush_start_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("flush_start_valid", {31'd0, bus.o_valid}, 32'd0);
    do_op(F_DIVU, 32'd100, 32'd7, res, lat, bcnt);
    chk("divu_100_7", res, 32'd14);

    // 6: async reset mid-CALC
    drive_start(F_DIV, 32'd1000, 32'd7);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   {31'd0, bus.o_busy},  32'd0);
    chk("arst_valid",  {31'd0, bus.o_valid}, 32'd0);
    chk("arst_result", bus.o_result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      if (bus.o_valid === 1'b1) seen++;
      @(negedge clk);
    end
    chk("arst_no_valid", 32'(seen), 32'd0);

    // Randomized vectors against the reference model
    for (int i = 0; i < 1000; i++) begin
      f   = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 15);
      case (sel)
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       a = 32'($urandom_range(0, 15));
        4:       b = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(f, a, b, res, lat, bcnt);
      chk("rand_result", res, ref_model(f, a, b));
      chk("rand_latency", 32'(lat), 32'(ref_latency(f, a, b)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
